fifo_scoreboard: RTL and testbench
==================================

# fifo_scoreboard

Synthesizable self-checking scoreboard that sits directly downstream of the 32-bit FIFO's observation interface, the same signal set the FIFO monitor prints. It keeps a cycle-accurate reference model of the FIFO contents, compares every DUT read word against the expected word byte-lane by byte-lane, and checks the DUT `full`/`empty` flags every cycle. Results are exposed as registered pulses and saturating counters, so a bench or an on-chip debug path can consume them without $display parsing.

## Interface
- `DATA_WIDTH`, 32, word width; must be a multiple of 8.
- `DEPTH`, 8, DUT FIFO depth in words; power of 2, ≥2.
- `CNT_WIDTH`, 16, width of error/transaction counters.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Wr_enable`  in  1  DUT write request, observed.
- `Read_enable`  in  1  DUT read request, observed.
- `data_in`  in  DATA_WIDTH  DUT write data, observed.
- `data_out`  in  DATA_WIDTH  DUT read data, observed.
- `full`  in  1  DUT full flag, observed.
- `empty`  in  1  DUT empty flag, observed.
- `mismatch`  out  1  one-cycle pulse: read data differed from expected.
- `lane_err`  out  DATA_WIDTH/8  byte lanes that differed (bit 0 = bits 7:0); valid with `mismatch`, else 0.
- `expected_data`  out  DATA_WIDTH  last expected word compared.
- `flag_error`  out  1  one-cycle pulse: DUT full/empty disagreed with model.
- `error_count`  out  CNT_WIDTH  total data + flag errors, saturating.
- `wr_count`  out  CNT_WIDTH  accepted writes, wrapping.
- `rd_count`  out  CNT_WIDTH  accepted reads, wrapping.
- `level`  out  $clog2(DEPTH)+1  model occupancy, 0..DEPTH.

## Operation
- Model: DEPTH-entry circular buffer, `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap naturally), occupancy `level`.
- Accepted write: `Wr_enable && level != DEPTH`; stores `data_in` at `wr_ptr`, increments `wr_ptr`, `wr_count`.
- Accepted read: `Read_enable && level != 0`; latches `model[rd_ptr]` into `expected_data`, sets `pend`, increments `rd_ptr`, `rd_count`.
- Write while model full, or read while model empty: ignored by model, not an error by itself.
- Simultaneous write+read: level 0 → write only; level DEPTH → read only (no pass-through); otherwise both, level unchanged.
- Data check: in the cycle after an accepted read (`pend`=1), compare `data_out` with `expected_data`; `lane_err[i]` = byte i differs; any difference → `mismatch`=1 for one cycle, `error_count`+1.
- Flag check, every non-reset cycle: `full` vs (level==DEPTH), `empty` vs (level==0); any disagreement → `flag_error` pulse, `error_count`+1.
- Data and flag errors in the same cycle add 2 to `error_count`.
- `error_count` saturates at all-ones; `wr_count`/`rd_count` wrap.
- Reset: pointers, `level`, `pend`, all outputs → 0; a pending compare is discarded.

## Timing
- All outputs registered; no combinational input→output path.
- Read accepted at edge N: `expected_data` valid after N; `data_out` sampled at edge N+1; `mismatch`/`lane_err` high during cycle after N+1, cleared after N+2 unless a new mismatch.
- Back-to-back reads: one compare per cycle, pipelined; `mismatch` may stay high on consecutive cycles.
- Flag check at edge N uses `level` before update at N; `flag_error` high for the cycle after N.
- `level`, `wr_count`, `rd_count` update at the edge of acceptance.
- Reset asserted at edge N: all outputs 0 after N; first check occurs at the first edge with `reset`=0.

## Test plan
- Reset, then write 0x04030201, 0x08070605, read twice with correct DUT data → `mismatch`=0, `error_count`=0, `wr_count`=2, `rd_count`=2, `level`=0.
- Read with `data_out`=0x04FF0201 vs expected 0x04030201 → one-cycle `mismatch`=1, `lane_err`=4'b0100, `error_count`=1.
- Fill 8 words, DUT `full`=0 at level 8 → `flag_error` pulse; 9th write ignored, `level` stays 8.
- At level 0 assert write+read together → only write accepted, `level`=1, no compare; at level 8 → only read accepted, `level`=7.
- Force 65535 errors then one more → `error_count` stays 16'hFFFF.
- Accept read, assert `reset` next cycle with wrong `data_out` → no `mismatch`, all outputs 0.

Source files
------------

// File: rtl/fifo_scoreboard.sv
// ---------------------------------------------------------------------------
// fifo_scoreboard
// Scoreboard for a FIFO. It watches the FIFO's observation interface and
// keeps a reference copy of the FIFO contents. It checks every read word byte
// lane by byte lane. It also checks the DUT full/empty flags on every cycle.
//
// Ports
//   clk           : single clock, rising edge
//   reset         : synchronous, active-high reset
//   Wr_enable     : observed DUT write request
//   Read_enable   : observed DUT read request
//   data_in       : observed DUT write data
//   data_out      : observed DUT read data (valid the cycle after a read)
//   full, empty   : observed DUT status flags
//   mismatch      : one-cycle pulse, read word differed from the model
//   lane_err      : per-byte difference mask, qualified by mismatch
//   expected_data : last word the model expected on data_out
//   flag_error    : one-cycle pulse, full/empty disagreed with the model
//   error_count   : data + flag errors, saturating
//   wr_count      : accepted writes, wrapping
//   rd_count      : accepted reads, wrapping
//   level         : model occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fifo_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        Wr_enable,
    input  logic                        Read_enable,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic [DATA_WIDTH-1:0]       data_out,
    input  logic                        full,
    input  logic                        empty,
    output logic                        mismatch,
    output logic [DATA_WIDTH/8-1:0]     lane_err,
    output logic [DATA_WIDTH-1:0]       expected_data,
    output logic                        flag_error,
    output logic [CNT_WIDTH-1:0]        error_count,
    output logic [CNT_WIDTH-1:0]        wr_count,
    output logic [CNT_WIDTH-1:0]        rd_count,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int LANES  = DATA_WIDTH / 8;
    localparam int LANE_W = 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Per-byte inequality mask between two words; bit i covers bits 8i+7:8i.
    function automatic logic [LANES-1:0] lane_diff(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [LANES-1:0] d;
        d = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            d[i] = |(a[i*LANE_W +: LANE_W] ^ b[i*LANE_W +: LANE_W]);
        end
        return d;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic                  pend_r;
    logic [DATA_WIDTH-1:0] expected_data_r;
    logic                  mismatch_r;
    logic [LANES-1:0]      lane_err_r;
    logic                  flag_error_r;
    logic [CNT_WIDTH-1:0]  error_count_r;
    logic [CNT_WIDTH-1:0]  wr_count_r;
    logic [CNT_WIDTH-1:0]  rd_count_r;

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [LVL_W-1:0]      level_nxt_s;
    logic [LANES-1:0]      lane_diff_s;
    logic                  data_err_s;
    logic                  flag_err_s;
    logic [1:0]            err_inc_s;
    logic [CNT_WIDTH:0]    err_sum_s;
    logic [CNT_WIDTH-1:0]  err_nxt_s;

    // Acceptance, compare and error-count arithmetic from the current model state.
    always_comb begin
        wr_acc_s    = Wr_enable && (level_r != FULL_LVL);
        rd_acc_s    = Read_enable && (level_r != {LVL_W{1'b0}});
        level_nxt_s = level_r;
        // Write-only grows, read-only shrinks, both (or neither) hold the level.
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase

        // A compare happens only in the cycle after an accepted read.
        if (pend_r) begin
            lane_diff_s = lane_diff(data_out, expected_data_r);
        end else begin
            lane_diff_s = {LANES{1'b0}};
        end
        data_err_s = |lane_diff_s;
        // The flags are judged against the occupancy before this edge's update.
        flag_err_s = (full  != (level_r == FULL_LVL)) ||
                     (empty != (level_r == {LVL_W{1'b0}}));

        err_inc_s = {1'b0, data_err_s} + {1'b0, flag_err_s};
        err_sum_s = {1'b0, error_count_r} + (CNT_WIDTH+1)'(err_inc_s);
        // Data and flag errors in the same cycle can add 2; the carry out
        // means the counter would wrap, so it clamps at all-ones instead.
        if (err_sum_s[CNT_WIDTH]) begin
            err_nxt_s = {CNT_WIDTH{1'b1}};
        end else begin
            err_nxt_s = err_sum_s[CNT_WIDTH-1:0];
        end
    end

    // Reference storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Model pointers, occupancy, counters and registered check results.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            level_r         <= {LVL_W{1'b0}};
            pend_r          <= 1'b0;
            expected_data_r <= {DATA_WIDTH{1'b0}};
            mismatch_r      <= 1'b0;
            lane_err_r      <= {LANES{1'b0}};
            flag_error_r    <= 1'b0;
            error_count_r   <= {CNT_WIDTH{1'b0}};
            wr_count_r      <= {CNT_WIDTH{1'b0}};
            rd_count_r      <= {CNT_WIDTH{1'b0}};
        end else begin
            level_r       <= level_nxt_s;
            pend_r        <= rd_acc_s;
            mismatch_r    <= data_err_s;
            lane_err_r    <= lane_diff_s;
            flag_error_r  <= flag_err_s;
            error_count_r <= err_nxt_s;
            if (wr_acc_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
                wr_count_r <= wr_count_r + CNT_WIDTH'(1);
            end
            if (rd_acc_s) begin
                expected_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
                rd_count_r      <= rd_count_r + CNT_WIDTH'(1);
            end
        end
    end

    assign mismatch      = mismatch_r;
    assign lane_err      = lane_err_r;
    assign expected_data = expected_data_r;
    assign flag_error    = flag_error_r;
    assign error_count   = error_count_r;
    assign wr_count      = wr_count_r;
    assign rd_count      = rd_count_r;
    assign level         = level_r;

endmodule

// File: tb/tb_fifo_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fifo_scoreboard
// Self-checking bench for fifo_scoreboard. The reference is a word queue that
// stands in for the FIFO contents, plus plain integer counters. Each cycle the
// bench predicts every scoreboard output from the rules for accepting, comparing
// and counting. It then checks all outputs one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_fifo_scoreboard;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          Wr_enable;
    logic          Read_enable;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          mismatch;
    logic [3:0]    lane_err;
    logic [DW-1:0] expected_data;
    logic          flag_error;
    logic [CW-1:0] error_count;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;
    logic [3:0]    level;

    always #5 clk = ~clk;

    fifo_scoreboard #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .Wr_enable     (Wr_enable),
        .Read_enable   (Read_enable),
        .data_in       (data_in),
        .data_out      (data_out),
        .full          (full),
        .empty         (empty),
        .mismatch      (mismatch),
        .lane_err      (lane_err),
        .expected_data (expected_data),
        .flag_error    (flag_error),
        .error_count   (error_count),
        .wr_count      (wr_count),
        .rd_count      (rd_count),
        .level         (level)
    );

    // Reference state
    logic [DW-1:0] q[$];
    bit            pend_m;
    logic [DW-1:0] exp_m;
    int            err_m, wr_m, rd_m;
    bit            mm_m, fe_m;
    logic [3:0]    lane_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Apply one cycle of inputs, advance the model, clock, then check all outputs.
    task automatic step(input bit rst, input bit we, input bit re,
                        input logic [DW-1:0] din, input logic [DW-1:0] dout,
                        input bit f, input bit e);
        bit wa, ra;
        reset = rst; Wr_enable = we; Read_enable = re;
        data_in = din; data_out = dout; full = f; empty = e;
        if (rst) begin
            q.delete();
            pend_m = 0; exp_m = '0; err_m = 0; wr_m = 0; rd_m = 0;
            mm_m = 0; fe_m = 0; lane_m = '0;
        end else begin
            lane_m = '0;
            if (pend_m)
                for (int i = 0; i < 4; i++)
                    if (dout[8*i +: 8] != exp_m[8*i +: 8]) lane_m[i] = 1'b1;
            mm_m = (lane_m != 4'd0);
            fe_m = (f != (q.size() == DEPTH)) || (e != (q.size() == 0));
            err_m = err_m + (mm_m ? 1 : 0) + (fe_m ? 1 : 0);
            if (err_m > 65535) err_m = 65535;
            wa = we && (q.size() != DEPTH);
            ra = re && (q.size() != 0);
            pend_m = ra;
            if (ra) begin
                exp_m = q.pop_front();
                rd_m = (rd_m + 1) % 65536;
            end
            if (wa) begin
                q.push_back(din);
                wr_m = (wr_m + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
        check_eq("mismatch",      64'(mismatch),      64'(mm_m));
        check_eq("lane_err",      64'(lane_err),      64'(lane_m));
        check_eq("flag_error",    64'(flag_error),    64'(fe_m));
        check_eq("expected_data", 64'(expected_data), 64'(exp_m));
        check_eq("error_count",   64'(error_count),   64'(err_m));
        check_eq("wr_count",      64'(wr_count),      64'(wr_m));
        check_eq("rd_count",      64'(rd_count),      64'(rd_m));
        check_eq("level",         64'(level),         64'(q.size()));
    endtask

    // Build DUT-side data/flags from the reference, with optional corruption.
    task automatic drive(input bit rst, input bit we, input bit re,
                         input logic [DW-1:0] din, input logic [DW-1:0] xor_mask,
                         input bit bad_full, input bit bad_empty);
        logic [DW-1:0] dout;
        bit f, e;
        dout = pend_m ? (exp_m ^ xor_mask) : DW'($urandom);
        f = (q.size() == DEPTH) ^ bad_full;
        e = (q.size() == 0) ^ bad_empty;
        step(rst, we, re, din, dout, f, e);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, '0, '0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; Wr_enable = 0; Read_enable = 0;
        data_in = '0; data_out = '0; full = 0; empty = 0;
        pend_m = 0; exp_m = '0; err_m = 0; wr_m = 0; rd_m = 0;
        mm_m = 0; fe_m = 0; lane_m = '0;
        @(negedge clk);

        // Basic write/read with correct data
        do_reset();
        check_eq("rst_level", 64'(level), 64'd0);
        drive(0, 1, 0, 32'h04030201, '0, 0, 0);
        drive(0, 1, 0, 32'h08070605, '0, 0, 0);
        drive(0, 0, 1, '0, '0, 0, 0);
        drive(0, 0, 1, '0, '0, 0, 0);
        drive(0, 0, 0, '0, '0, 0, 0);
        check_eq("tp1_err", 64'(error_count), 64'd0);
        check_eq("tp1_wr",  64'(wr_count),    64'd2);
        check_eq("tp1_rd",  64'(rd_count),    64'd2);
        check_eq("tp1_lvl", 64'(level),       64'd0);

        // Corrupted byte lane 2: data_out = 0x04FF0201
        do_reset();
        drive(0, 1, 0, 32'h04030201, '0, 0, 0);
        drive(0, 0, 1, '0, '0, 0, 0);
        drive(0, 0, 0, '0, 32'h00FC0000, 0, 0);
        check_eq("tp2_mm",   64'(mismatch),    64'd1);
        check_eq("tp2_lane", 64'(lane_err),    64'h4);
        check_eq("tp2_err",  64'(error_count), 64'd1);
        drive(0, 0, 0, '0, '0, 0, 0);
        check_eq("tp2_mm_clr", 64'(mismatch), 64'd0);

        // Fill, wrong full flag at level 8, ninth write ignored
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, DW'($urandom), '0, 0, 0);
        check_eq("tp3_lvl8", 64'(level), 64'd8);
        drive(0, 1, 0, 32'hDEADBEEF, '0, 1, 0);
        check_eq("tp3_fe",   64'(flag_error), 64'd1);
        check_eq("tp3_lvl",  64'(level),      64'd8);
        check_eq("tp3_wr",   64'(wr_count),   64'd8);
        drive(0, 0, 0, '0, '0, 0, 0);
        check_eq("tp3_fe_clr", 64'(flag_error), 64'd0);

        // Simultaneous write+read at the empty and full boundaries
        do_reset();
        drive(0, 1, 1, 32'hA5A5A5A5, '0, 0, 0);
        check_eq("tp4_lvl1", 64'(level),    64'd1);
        check_eq("tp4_rd0",  64'(rd_count), 64'd0);
        drive(0, 0, 0, '0, '0, 0, 0);
        check_eq("tp4_nocmp", 64'(mismatch), 64'd0);
        for (int i = 0; i < DEPTH - 1; i++) drive(0, 1, 0, DW'($urandom), '0, 0, 0);
        drive(0, 1, 1, 32'h11111111, '0, 0, 0);
        check_eq("tp4_lvl7", 64'(level),    64'd7);
        check_eq("tp4_wr8",  64'(wr_count), 64'd8);
        check_eq("tp4_exp",  64'(expected_data), 64'hA5A5A5A5);
        drive(0, 0, 0, '0, '0, 0, 0);

        // Saturation: data + flag error every cycle while streaming at level 4
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 1, 0, DW'($urandom), '0, 0, 0);
        for (int i = 0; i < 32771; i++) drive(0, 1, 1, DW'($urandom), 32'h1, 1, 0);
        check_eq("tp5_sat", 64'(error_count), 64'hFFFF);

        // Reset right after an accepted read discards the pending compare
        do_reset();
        drive(0, 1, 0, 32'hCAFEF00D, '0, 0, 0);
        drive(0, 0, 1, '0, '0, 0, 0);
        drive(1, 0, 0, '0, 32'hFFFFFFFF, 0, 0);
        check_eq("tp6_mm",  64'(mismatch),      64'd0);
        check_eq("tp6_exp", 64'(expected_data), 64'd0);
        drive(0, 0, 0, '0, 32'hFFFFFFFF, 0, 0);
        check_eq("tp6_mm2", 64'(mismatch), 64'd0);

        // Randomized traffic with occasional corruption and resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [DW-1:0] mask;
            mask = ($urandom_range(0, 7) == 0) ? DW'($urandom) : '0;
            drive(($urandom_range(0, 59) == 0), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), DW'($urandom), mask,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
